// File: rtl/mmcm_lock_pkg.sv
// Shared types and defaults for the MMCM lock controller.
package mmcm_lock_pkg;

   typedef enum logic [2:0] {
      S_RST,
      S_WAIT,
      S_STABLE,
      S_RUN,
      S_FAIL
   } lock_state_t;

   localparam int unsigned DEF_RST_PULSE_CYC    = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 100000;
   localparam int unsigned DEF_LOCK_STABLE_CYC  = 1024;
   localparam int unsigned DEF_MAX_RETRY        = 3;
   localparam int unsigned LOSS_CNT_W           = 8;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer; both stages reset to zero.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/mmcm_lock_ctrl.sv
// MMCM reset sequencer: pulses reset, waits for lock with timeout/retry, qualifies
// lock stability and drives a registered downstream reset.
module mmcm_lock_ctrl
   import mmcm_lock_pkg::*;
#(
   parameter int unsigned RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
   parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
   parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
   parameter int unsigned MAX_RETRY        = DEF_MAX_RETRY
) (
   input  logic                           sys_clk,
   input  logic                           sys_rst_n,
   input  logic                           locked,
   input  logic                           err_clr,
   output logic                           mmcm_rst,
   output logic                           rst_out_n,
   output logic                           lock_err,
   output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
   output logic [LOSS_CNT_W-1:0]          loss_cnt
);

   localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);
   localparam int unsigned CNT_MAX = max3(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
   // Counter only ever holds 0..CNT_MAX-1 before the state changes.
   localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

   logic                  locked_s;
   lock_state_t           state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [RETRY_W-1:0]    retry_q, retry_d, retry_inc;
   logic [LOSS_CNT_W-1:0] loss_q, loss_d;
   logic                  mmcm_rst_q, mmcm_rst_d;
   logic                  rst_out_n_q, rst_out_n_d;
   logic                  lock_err_q, lock_err_d;

   sync_2ff #(
      .WIDTH (1)
   ) u_lock_sync (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .d     (locked),
      .q     (locked_s)
   );

   assign retry_inc = retry_q + RETRY_W'(1);

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      loss_d  = loss_q;
      unique case (state_q)
         S_RST: begin
            if (cnt_q == RST_LAST) state_d = S_WAIT;
         end
         S_WAIT: begin
            // A lock seen on the expiry cycle takes precedence over the timeout.
            if (locked_s) begin
               state_d = S_STABLE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               retry_d = retry_inc;
               state_d = (retry_inc == RETRY_LIMIT) ? S_FAIL : S_RST;
            end
         end
         S_STABLE: begin
            if (!locked_s) begin
               state_d = S_WAIT;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = S_RUN;
               retry_d = '0;
            end
         end
         S_RUN: begin
            if (!locked_s) begin
               state_d = S_RST;
               if (loss_q != '1) loss_d = loss_q + LOSS_CNT_W'(1);
            end
         end
         S_FAIL: begin
            if (err_clr) begin
               state_d = S_RST;
               retry_d = '0;
            end
         end
         default: state_d = S_RST;
      endcase

      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (state_q inside {S_RST, S_WAIT, S_STABLE}) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      mmcm_rst_d  = (state_d == S_RST) || (state_d == S_FAIL);
      rst_out_n_d = (state_d == S_RUN);
      lock_err_d  = (state_d == S_FAIL);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= S_RST;
         cnt_q       <= '0;
         retry_q     <= '0;
         loss_q      <= '0;
         mmcm_rst_q  <= 1'b1;
         rst_out_n_q <= 1'b0;
         lock_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         loss_q      <= loss_d;
         mmcm_rst_q  <= mmcm_rst_d;
         rst_out_n_q <= rst_out_n_d;
         lock_err_q  <= lock_err_d;
      end
   end

   assign mmcm_rst  = mmcm_rst_q;
   assign rst_out_n = rst_out_n_q;
   assign lock_err  = lock_err_q;
   assign retry_cnt = retry_q;
   assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_mmcm_lock_ctrl.sv
// Bench for mmcm_lock_ctrl: directed vector table, boundary sequences and a random run
// checked every cycle against a timestamp-based phase model.
module tb_mmcm_lock_ctrl;

   localparam int unsigned P_RST = 4;
   localparam int unsigned P_TO  = 50;
   localparam int unsigned P_ST  = 8;
   localparam int unsigned P_MR  = 2;

   localparam int PH_PULSE = 0;
   localparam int PH_WAIT  = 1;
   localparam int PH_QUAL  = 2;
   localparam int PH_UP    = 3;
   localparam int PH_DEAD  = 4;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic       locked;
   logic       err_clr;
   logic       mmcm_rst;
   logic       rst_out_n;
   logic       lock_err;
   logic [1:0] retry_cnt;
   logic [7:0] loss_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 sys_clk = ~sys_clk;

   mmcm_lock_ctrl #(
      .RST_PULSE_CYC    (P_RST),
      .LOCK_TIMEOUT_CYC (P_TO),
      .LOCK_STABLE_CYC  (P_ST),
      .MAX_RETRY        (P_MR)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .locked    (locked),
      .err_clr   (err_clr),
      .mmcm_rst  (mmcm_rst),
      .rst_out_n (rst_out_n),
      .lock_err  (lock_err),
      .retry_cnt (retry_cnt),
      .loss_cnt  (loss_cnt)
   );

   logic [31:0] dut_vec;
   assign dut_vec = {19'b0, mmcm_rst, rst_out_n, lock_err, retry_cnt, loss_cnt};

   // Reference model: phase plus entry timestamp; history of raw locked samples.
   typedef struct {
      int   phase;
      int   cyc;
      int   entered;
      int   retry;
      int   loss;
      logic s0;
      logic s1;
   } model_t;

   function automatic model_t model_reset();
      model_t m;
      m.phase = PH_PULSE; m.cyc = 0; m.entered = 0;
      m.retry = 0; m.loss = 0; m.s0 = 1'b0; m.s1 = 1'b0;
      return m;
   endfunction

   function automatic model_t model_step(model_t m, logic lk, logic clr);
      model_t n;
      int     k;
      n = m;
      n.cyc = m.cyc + 1;
      n.s0 = lk;
      n.s1 = m.s0;
      k = n.cyc - m.entered;
      case (m.phase)
         PH_PULSE: if (k >= int'(P_RST)) n.phase = PH_WAIT;
         PH_WAIT: begin
            if (m.s1) n.phase = PH_QUAL;
            else if (k >= int'(P_TO)) begin
               n.retry = m.retry + 1;
               n.phase = (n.retry >= int'(P_MR)) ? PH_DEAD : PH_PULSE;
            end
         end
         PH_QUAL: begin
            if (!m.s1) n.phase = PH_WAIT;
            else if (k >= int'(P_ST)) begin
               n.phase = PH_UP;
               n.retry = 0;
            end
         end
         PH_UP: begin
            if (!m.s1) begin
               n.phase = PH_PULSE;
               n.loss = (m.loss < 255) ? m.loss + 1 : 255;
            end
         end
         default: begin
            if (clr) begin
               n.phase = PH_PULSE;
               n.retry = 0;
            end
         end
      endcase
      if (n.phase != m.phase) n.entered = n.cyc;
      return n;
   endfunction

   function automatic logic [31:0] model_out(model_t m);
      logic mm, rn, er;
      mm = (m.phase == PH_PULSE) || (m.phase == PH_DEAD);
      rn = (m.phase == PH_UP);
      er = (m.phase == PH_DEAD);
      return {19'b0, mm, rn, er, 2'(m.retry), 8'(m.loss)};
   endfunction

   model_t mdl;

   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) mdl <= model_reset();
      else            mdl <= model_step(mdl, locked, err_clr);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h (mmcm,rstn,err,retry,loss)", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
      check("model", dut_vec, model_out(mdl));
   endtask

   task automatic adv(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   function automatic logic [31:0] pack(input logic m, input logic r, input logic e,
                                        input logic [1:0] rt, input logic [7:0] ls);
      return {19'b0, m, r, e, rt, ls};
   endfunction

   typedef struct {
      int         n;
      logic       lk;
      logic       clr;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input int n, input logic lk, input logic clr, input logic m,
                          input logic r, input logic e, input logic [1:0] rt,
                          input logic [7:0] ls);
      vec_t v;
      v.n = n; v.lk = lk; v.clr = clr; v.exp = pack(m, r, e, rt, ls);
      vecs.push_back(v);
   endtask

   initial begin
      sys_rst_n = 1'b0;
      locked    = 1'b0;
      err_clr   = 1'b0;

      // n, locked, err_clr -> mmcm_rst, rst_out_n, lock_err, retry_cnt, loss_cnt
      add_vec( 3, 0, 0, 1, 0, 0, 0, 0);  // pulse still on
      add_vec( 1, 0, 0, 0, 0, 0, 0, 0);  // pulse ends after 4 cycles
      add_vec( 6, 0, 0, 0, 0, 0, 0, 0);
      add_vec(10, 1, 0, 0, 0, 0, 0, 0);  // lock raised 10 cycles after release
      add_vec( 1, 1, 0, 0, 1, 0, 0, 0);  // release 11 cycles after the edge
      add_vec( 1, 0, 0, 0, 1, 0, 0, 0);  // one-cycle loss
      add_vec( 1, 1, 0, 0, 1, 0, 0, 0);
      add_vec( 1, 1, 0, 1, 0, 0, 0, 1);  // rst_out_n low 3 cycles after the drop
      add_vec( 3, 1, 0, 1, 0, 0, 0, 1);
      add_vec( 1, 1, 0, 0, 0, 0, 0, 1);
      add_vec( 8, 1, 0, 0, 0, 0, 0, 1);
      add_vec( 1, 1, 0, 0, 1, 0, 0, 1);  // re-locked
      add_vec( 3, 0, 0, 1, 0, 0, 0, 2);
      add_vec( 4, 0, 0, 0, 0, 0, 0, 2);  // WAIT
      add_vec( 5, 1, 0, 0, 0, 0, 0, 2);  // glitch high
      add_vec( 3, 0, 0, 0, 0, 0, 0, 2);  // glitch low
      add_vec(10, 1, 0, 0, 0, 0, 0, 2);
      add_vec( 1, 1, 0, 0, 1, 0, 0, 2);  // release 11 after final rise
      add_vec( 3, 0, 0, 1, 0, 0, 0, 3);
      add_vec( 4, 0, 0, 0, 0, 0, 0, 3);
      add_vec(49, 0, 0, 0, 0, 0, 0, 3);
      add_vec( 1, 0, 0, 1, 0, 0, 1, 3);  // first timeout
      add_vec( 4, 0, 0, 0, 0, 0, 1, 3);
      add_vec(49, 0, 0, 0, 0, 0, 1, 3);
      add_vec( 1, 0, 0, 1, 0, 1, 2, 3);  // second timeout -> FAIL
      add_vec( 5, 1, 0, 1, 0, 1, 2, 3);
      add_vec( 1, 1, 1, 1, 0, 0, 0, 3);  // err_clr
      add_vec( 3, 1, 0, 1, 0, 0, 0, 3);
      add_vec( 1, 1, 0, 0, 0, 0, 0, 3);
      add_vec( 8, 1, 0, 0, 0, 0, 0, 3);
      add_vec( 1, 1, 0, 0, 1, 0, 0, 3);
      add_vec( 1, 1, 1, 0, 1, 0, 0, 3);  // err_clr ignored in RUN

      adv(3);
      check("reset_values", dut_vec, pack(1, 0, 0, 2'd0, 8'd0));
      sys_rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         locked  = vecs[i].lk;
         err_clr = vecs[i].clr;
         adv(vecs[i].n);
         check($sformatf("vec%0d", i), dut_vec, vecs[i].exp);
      end

      // Async reset at WAIT cycle 20.
      err_clr = 1'b0;
      locked  = 1'b0;
      adv(27);
      check("pre_async_rst", dut_vec, pack(0, 0, 0, 2'd0, 8'd4));
      sys_rst_n = 1'b0;
      #1;
      check("async_rst_now", dut_vec, pack(1, 0, 0, 2'd0, 8'd0));
      adv(2);
      sys_rst_n = 1'b1;
      adv(3);
      check("fresh_pulse_on", dut_vec, pack(1, 0, 0, 2'd0, 8'd0));
      adv(1);
      check("fresh_pulse_off", dut_vec, pack(0, 0, 0, 2'd0, 8'd0));

      // Lock arrives on the timeout expiry cycle.
      adv(47);
      locked = 1'b1;
      adv(2);
      check("pre_expiry", dut_vec, pack(0, 0, 0, 2'd0, 8'd0));
      adv(1);
      check("rise_beats_timeout", dut_vec, pack(0, 0, 0, 2'd0, 8'd0));
      // Lock drops on the stability completion cycle.
      adv(5);
      locked = 1'b0;
      adv(3);
      check("fall_beats_stable", dut_vec, pack(0, 0, 0, 2'd0, 8'd0));
      locked = 1'b1;
      adv(10);
      check("relock_pending", dut_vec, pack(0, 0, 0, 2'd0, 8'd0));
      adv(1);
      check("relock_release", dut_vec, pack(0, 1, 0, 2'd0, 8'd0));

      // Drive loss_cnt into saturation.
      for (int i = 0; i < 262; i++) begin
         locked = 1'b0;
         adv(1);
         locked = 1'b1;
         adv(25);
      end
      check("loss_saturated", dut_vec, pack(0, 1, 0, 2'd0, 8'd255));

      // Random run against the model.
      begin
         int   cycles;
         int   hold;
         logic lv;
         cycles = 0;
         lv = locked;
         while (cycles < 4000) begin
            lv = ~lv;
            if (lv) hold = $urandom_range(1, 30);
            else if ($urandom_range(0, 5) == 0) hold = $urandom_range(40, 160);
            else hold = $urandom_range(1, 12);
            locked = lv;
            for (int h = 0; h < hold; h++) begin
               err_clr = ($urandom_range(0, 29) == 0);
               if ($urandom_range(0, 599) == 0) begin
                  sys_rst_n = 1'b0;
                  step();
                  sys_rst_n = 1'b1;
               end
               step();
               cycles++;
            end
         end
         err_clr = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
